// File: rtl/spram_arbiter.sv
// spram_arbiter: shares one 16K x 16 single-port SPRAM between port A (CPU)
// and port B (video/DMA). One access is accepted per clock. The acknowledge
// and the RAM-side address/data/write-enable are registered. Read data comes
// back to the granted port two cycles after the acknowledging edge.
// Optional build macro SPRAM_ARB_FIXED_PRIO_EN: port A always wins contention
// and port B is only served when A is idle. Otherwise the arbiter alternates
// between the ports when both request.
module spram_arbiter (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        a_req,
   input  logic        a_we,
   input  logic [13:0] a_addr,
   input  logic [15:0] a_wdata,
   output logic        a_ack,
   output logic        a_rvalid,
   output logic [15:0] a_rdata,
   input  logic        b_req,
   input  logic        b_we,
   input  logic [13:0] b_addr,
   input  logic [15:0] b_wdata,
   output logic        b_ack,
   output logic        b_rvalid,
   output logic [15:0] b_rdata,
   output logic [13:0] ram_addr,
   output logic [15:0] ram_data_in,
   output logic        ram_we,
   input  logic [15:0] ram_data_out
);

   typedef enum logic {
      PORT_A = 1'b0,
      PORT_B = 1'b1
   } port_t;

   logic  grant_a;
   logic  grant_b;

   // Read tag: stage 1 is the access sitting on the RAM inputs, stage 2 is
   // the access whose data is on ram_data_out.
   logic  tag1_valid;
   port_t tag1_port;
   logic  tag2_valid;
   port_t tag2_port;

`ifdef SPRAM_ARB_FIXED_PRIO_EN
   // Fixed priority grant: A always wins, B only when A is idle.
   always_comb begin
      grant_a = a_req;
      grant_b = b_req & ~a_req;
   end
`else
   port_t last_q;

   // Round-robin grant: on contention serve the port that did not win last.
   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      if (a_req && b_req) begin
         if (last_q == PORT_B) begin
            grant_a = 1'b1;
         end else begin
            grant_b = 1'b1;
         end
      end else begin
         grant_a = a_req;
         grant_b = b_req;
      end
   end

   // Remember the last granted port; idle cycles leave it unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= PORT_B;
      end else if (grant_a) begin
         last_q <= PORT_A;
      end else if (grant_b) begin
         last_q <= PORT_B;
      end
   end
`endif

   // Request stage: register ack, RAM inputs and the read tag for the winner.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_ack       <= 1'b0;
         b_ack       <= 1'b0;
         ram_addr    <= 14'd0;
         ram_data_in <= 16'd0;
         ram_we      <= 1'b0;
         tag1_valid  <= 1'b0;
         tag1_port   <= PORT_A;
      end else begin
         a_ack <= grant_a;
         b_ack <= grant_b;
         if (grant_a) begin
            ram_addr    <= a_addr;
            ram_data_in <= a_wdata;
            ram_we      <= a_we;
            tag1_valid  <= ~a_we;
            tag1_port   <= PORT_A;
         end else if (grant_b) begin
            ram_addr    <= b_addr;
            ram_data_in <= b_wdata;
            ram_we      <= b_we;
            tag1_valid  <= ~b_we;
            tag1_port   <= PORT_B;
         end else begin
            ram_we     <= 1'b0;
            tag1_valid <= 1'b0;
         end
      end
   end

   // Tag follows the access while the SPRAM performs the read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag2_valid <= 1'b0;
         tag2_port  <= PORT_A;
      end else begin
         tag2_valid <= tag1_valid;
         tag2_port  <= tag1_port;
      end
   end

   // Return stage: capture RAM data into the tagged port only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_rvalid <= 1'b0;
         b_rvalid <= 1'b0;
         a_rdata  <= 16'd0;
         b_rdata  <= 16'd0;
      end else begin
         a_rvalid <= tag2_valid && (tag2_port == PORT_A);
         b_rvalid <= tag2_valid && (tag2_port == PORT_B);
         if (tag2_valid && (tag2_port == PORT_A)) begin
            a_rdata <= ram_data_out;
         end
         if (tag2_valid && (tag2_port == PORT_B)) begin
            b_rdata <= ram_data_out;
         end
      end
   end

endmodule

// File: tb/tb_spram_arbiter.sv
// Testbench for spram_arbiter: a behavioural SPRAM, a shadow memory and
// per-port queues of expected read data with the cycle it must appear in.
// Define SPRAM_ARB_FIXED_PRIO_EN to exercise the fixed-priority build.
module tb_spram_arbiter;

   logic        clk;
   logic        rst_n;
   logic        a_req, a_we, b_req, b_we;
   logic [13:0] a_addr, b_addr;
   logic [15:0] a_wdata, b_wdata;
   logic        a_ack, a_rvalid, b_ack, b_rvalid;
   logic [15:0] a_rdata, b_rdata;
   logic [13:0] ram_addr;
   logic [15:0] ram_data_in;
   logic        ram_we;
   logic [15:0] ram_data_out;

   typedef struct {
      logic [15:0] data;
      int          cycle;
   } exp_t;

   exp_t        qa[$];
   exp_t        qb[$];
   logic [15:0] mem    [0:16383];
   logic [15:0] shadow [0:16383];
   logic        exp_last;
   int          cyc;
   int          checks;
   int          passes;

   spram_arbiter dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .a_req        (a_req),
      .a_we         (a_we),
      .a_addr       (a_addr),
      .a_wdata      (a_wdata),
      .a_ack        (a_ack),
      .a_rvalid     (a_rvalid),
      .a_rdata      (a_rdata),
      .b_req        (b_req),
      .b_we         (b_we),
      .b_addr       (b_addr),
      .b_wdata      (b_wdata),
      .b_ack        (b_ack),
      .b_rvalid     (b_rvalid),
      .b_rdata      (b_rdata),
      .ram_addr     (ram_addr),
      .ram_data_in  (ram_data_in),
      .ram_we       (ram_we),
      .ram_data_out (ram_data_out)
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Count rising edges so expected read cycles can be checked.
   always @(posedge clk) begin
      cyc = cyc + 1;
   end

   // Behavioural synchronous single-port RAM.
   always @(posedge clk) begin
      if (ram_we) begin
         mem[ram_addr] <= ram_data_in;
      end
      ram_data_out <= mem[ram_addr];
   end

   // Scoreboard: every rvalid must match the oldest expected read of that port.
   always @(negedge clk) begin
      exp_t e;
      if (a_rvalid === 1'b1) begin
         checks = checks + 1;
         if (qa.size() == 0) begin
            $display("[TB] FAIL a_rvalid_unexpected: got rdata %h at cycle %0d, required no rvalid", a_rdata, cyc);
         end else begin
            e = qa.pop_front();
            if (a_rdata !== e.data || cyc != e.cycle) begin
               $display("[TB] FAIL a_read: got %h at cycle %0d, required %h at cycle %0d", a_rdata, cyc, e.data, e.cycle);
            end else begin
               passes = passes + 1;
            end
         end
      end
      if (b_rvalid === 1'b1) begin
         checks = checks + 1;
         if (qb.size() == 0) begin
            $display("[TB] FAIL b_rvalid_unexpected: got rdata %h at cycle %0d, required no rvalid", b_rdata, cyc);
         end else begin
            e = qb.pop_front();
            if (b_rdata !== e.data || cyc != e.cycle) begin
               $display("[TB] FAIL b_read: got %h at cycle %0d, required %h at cycle %0d", b_rdata, cyc, e.data, e.cycle);
            end else begin
               passes = passes + 1;
            end
         end
      end
   end

   task automatic step();
      @(negedge clk);
   endtask

   // Predicted {grant_b, grant_a} for the current requests.
   function automatic logic [1:0] predict(input logic ar, input logic br);
`ifdef SPRAM_ARB_FIXED_PRIO_EN
      return {br & ~ar, ar};
`else
      if (ar && br) begin
         return exp_last ? 2'b01 : 2'b10;
      end
      return {br, ar};
`endif
   endfunction

   // Record a grant observed at the most recent edge in the reference model.
   task automatic expect_grant(input logic port, input logic we,
                               input logic [13:0] addr, input logic [15:0] wdata);
      exp_t e;
      exp_last = port;
      if (we) begin
         shadow[addr] = wdata;
      end else begin
         e.data  = shadow[addr];
         e.cycle = cyc + 2;
         if (port == 1'b0) qa.push_back(e);
         else              qb.push_back(e);
      end
   endtask

   task automatic test_reset();
      logic [66:0] snap;
      rst_n = 1'b0;
      a_req = 1'b1; a_we = 1'b0; a_addr = 14'h0000; a_wdata = 16'h0;
      b_req = 1'b1; b_we = 1'b0; b_addr = 14'h0010; b_wdata = 16'h0;
      exp_last = 1'b1;
      qa.delete();
      qb.delete();
      for (int i = 0; i < 3; i++) begin
         step();
         snap = {a_ack, a_rvalid, a_rdata, b_ack, b_rvalid, b_rdata, ram_addr, ram_data_in, ram_we};
         checks = checks + 1;
         if (snap !== 67'd0) $display("[TB] FAIL reset_outputs: got %h, required 0", snap);
         else passes = passes + 1;
      end
      rst_n = 1'b1;
      step();
      checks = checks + 1;
      if ({b_ack, a_ack} !== 2'b01) $display("[TB] FAIL reset_first_grant: got {b,a}=%b, required 01", {b_ack, a_ack});
      else passes = passes + 1;
      expect_grant(1'b0, 1'b0, 14'h0000, 16'h0);
      a_req = 1'b0;
      step();
      checks = checks + 1;
      if ({b_ack, a_ack} !== 2'b10) $display("[TB] FAIL reset_second_grant: got {b,a}=%b, required 10", {b_ack, a_ack});
      else passes = passes + 1;
      expect_grant(1'b1, 1'b0, 14'h0010, 16'h0);
      b_req = 1'b0;
      repeat (4) step();
      checks = checks + 1;
      if (qa.size() + qb.size() != 0) $display("[TB] FAIL reset_drain: got %0d reads outstanding, required 0", qa.size() + qb.size());
      else passes = passes + 1;
   endtask

   task automatic test_single_port();
      a_req = 1'b1; a_we = 1'b1; a_addr = 14'h1234; a_wdata = 16'hBEEF;
      step();
      checks = checks + 1;
      if ({a_ack, ram_we, ram_addr, ram_data_in} !== {1'b1, 1'b1, 14'h1234, 16'hBEEF})
         $display("[TB] FAIL write_ram_side: got ack=%b we=%b addr=%h data=%h, required 1 1 1234 beef", a_ack, ram_we, ram_addr, ram_data_in);
      else passes = passes + 1;
      expect_grant(1'b0, 1'b1, 14'h1234, 16'hBEEF);
      a_we = 1'b0;
      step();
      checks = checks + 1;
      if ({a_ack, b_ack, ram_we} !== 3'b100) $display("[TB] FAIL back_to_back_read: got ack_a/ack_b/we=%b, required 100", {a_ack, b_ack, ram_we});
      else passes = passes + 1;
      expect_grant(1'b0, 1'b0, 14'h1234, 16'h0);
      a_req = 1'b0;
      a_addr = 14'h2222;
      step();
      checks = checks + 1;
      if ({a_ack, ram_we, ram_addr} !== {1'b0, 1'b0, 14'h1234})
         $display("[TB] FAIL idle_hold: got ack=%b we=%b addr=%h, required 0 0 1234", a_ack, ram_we, ram_addr);
      else passes = passes + 1;
      repeat (3) step();
      checks = checks + 1;
      if (qa.size() + qb.size() != 0) $display("[TB] FAIL single_drain: got %0d reads outstanding, required 0", qa.size() + qb.size());
      else passes = passes + 1;
   endtask

   task automatic test_contention();
      logic       a_pend, b_pend;
      logic [1:0] g;
      a_pend = 1'b1; b_pend = 1'b1;
      a_we = 1'b1; a_addr = 14'h0000; a_wdata = 16'h1111;
      b_we = 1'b1; b_addr = 14'h3FFF; b_wdata = 16'h2222;
      for (int i = 0; i < 4 && (a_pend || b_pend); i++) begin
         a_req = a_pend;
         b_req = b_pend;
         g = predict(a_req, b_req);
         step();
         checks = checks + 1;
         if ({b_ack, a_ack} !== g) $display("[TB] FAIL preload_grant: got {b,a}=%b, required %b", {b_ack, a_ack}, g);
         else passes = passes + 1;
         if (g[0]) begin expect_grant(1'b0, 1'b1, 14'h0000, 16'h1111); a_pend = 1'b0; end
         if (g[1]) begin expect_grant(1'b1, 1'b1, 14'h3FFF, 16'h2222); b_pend = 1'b0; end
      end
      a_req = 1'b1; a_we = 1'b0;
      b_req = 1'b1; b_we = 1'b0;
      for (int i = 0; i < 8; i++) begin
         g = predict(1'b1, 1'b1);
         step();
         checks = checks + 1;
         if ({b_ack, a_ack} !== g) $display("[TB] FAIL contention_grant: got {b,a}=%b, required %b", {b_ack, a_ack}, g);
         else passes = passes + 1;
         if (g[0]) expect_grant(1'b0, 1'b0, 14'h0000, 16'h0);
         if (g[1]) expect_grant(1'b1, 1'b0, 14'h3FFF, 16'h0);
      end
      a_req = 1'b0;
      b_req = 1'b0;
      repeat (4) step();
      checks = checks + 1;
      if (qa.size() + qb.size() != 0) $display("[TB] FAIL contention_drain: got %0d reads outstanding, required 0", qa.size() + qb.size());
      else passes = passes + 1;
   endtask

   task automatic test_coherence();
      b_req = 1'b1; b_we = 1'b1; b_addr = 14'h0100; b_wdata = 16'h00A5;
      step();
      checks = checks + 1;
      if ({b_ack, a_ack} !== 2'b10) $display("[TB] FAIL coherence_write: got {b,a}=%b, required 10", {b_ack, a_ack});
      else passes = passes + 1;
      expect_grant(1'b1, 1'b1, 14'h0100, 16'h00A5);
      b_req = 1'b0;
      a_req = 1'b1; a_we = 1'b0; a_addr = 14'h0100;
      step();
      checks = checks + 1;
      if ({b_ack, a_ack} !== 2'b01) $display("[TB] FAIL coherence_read: got {b,a}=%b, required 01", {b_ack, a_ack});
      else passes = passes + 1;
      expect_grant(1'b0, 1'b0, 14'h0100, 16'h0);
      a_req = 1'b0;
      repeat (4) step();
      checks = checks + 1;
      if (qa.size() + qb.size() != 0) $display("[TB] FAIL coherence_drain: got %0d reads outstanding, required 0", qa.size() + qb.size());
      else passes = passes + 1;
   endtask

   task automatic test_reset_mid_read();
      a_req = 1'b1; a_we = 1'b0; a_addr = 14'h1234;
      step();
      checks = checks + 1;
      if (a_ack !== 1'b1) $display("[TB] FAIL midreset_read_ack: got %b, required 1", a_ack);
      else passes = passes + 1;
      a_req = 1'b0;
      b_req = 1'b1; b_we = 1'b1; b_addr = 14'h0200; b_wdata = 16'h5555;
      step();
      checks = checks + 1;
      if ({b_ack, ram_we} !== 2'b11) $display("[TB] FAIL midreset_write_ack: got ack/we=%b, required 11", {b_ack, ram_we});
      else passes = passes + 1;
      rst_n = 1'b0;
      #1;
      checks = checks + 1;
      if ({ram_we, b_ack} !== 2'b00) $display("[TB] FAIL midreset_async: got we/ack=%b, required 00", {ram_we, b_ack});
      else passes = passes + 1;
      b_req = 1'b0;
      exp_last = 1'b1;
      qa.delete();
      qb.delete();
      step();
      checks = checks + 1;
      if (ram_we !== 1'b0) $display("[TB] FAIL midreset_we_held: got %b, required 0", ram_we);
      else passes = passes + 1;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         checks = checks + 1;
         if (a_rvalid !== 1'b0) $display("[TB] FAIL midreset_no_rvalid: got %b at cycle %0d, required 0", a_rvalid, cyc);
         else passes = passes + 1;
      end
   endtask

`ifdef SPRAM_ARB_FIXED_PRIO_EN
   task automatic test_fixed_prio();
      a_req = 1'b1; a_we = 1'b0; a_addr = 14'h0000;
      b_req = 1'b1; b_we = 1'b0; b_addr = 14'h3FFF;
      for (int i = 0; i < 6; i++) begin
         step();
         checks = checks + 1;
         if ({b_ack, a_ack} !== 2'b01) $display("[TB] FAIL fixed_prio_grant: got {b,a}=%b, required 01", {b_ack, a_ack});
         else passes = passes + 1;
         expect_grant(1'b0, 1'b0, 14'h0000, 16'h0);
      end
      a_req = 1'b0;
      step();
      checks = checks + 1;
      if ({b_ack, a_ack} !== 2'b10) $display("[TB] FAIL fixed_prio_b_served: got {b,a}=%b, required 10", {b_ack, a_ack});
      else passes = passes + 1;
      expect_grant(1'b1, 1'b0, 14'h3FFF, 16'h0);
      b_req = 1'b0;
      repeat (4) step();
      checks = checks + 1;
      if (qa.size() + qb.size() != 0) $display("[TB] FAIL fixed_prio_drain: got %0d reads outstanding, required 0", qa.size() + qb.size());
      else passes = passes + 1;
   endtask
`endif

   // Test sequence.
   initial begin
      cyc    = 0;
      checks = 0;
      passes = 0;
      for (int i = 0; i < 16384; i++) begin
         mem[i]    = 16'h0000;
         shadow[i] = 16'h0000;
      end
      $display("[TB] starting spram_arbiter tests");
      test_reset();
      test_single_port();
      test_contention();
      test_coherence();
      test_reset_mid_read();
`ifdef SPRAM_ARB_FIXED_PRIO_EN
      test_fixed_prio();
`endif
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/spram_arbiter.md
# spram_arbiter

Two-port round-robin arbiter that shares one 16K x 16 single-port SPRAM (`ice_spram` instance) between two requesters: port A (CPU) and port B (video/DMA). It accepts at most one access per clock, registers address, write data and write enable toward the SPRAM, and returns read data to the granted port with a fixed latency. It sits between the CPU/video bus logic and the `ice_spram` wrapper.

## Interface
- No parameters; widths are fixed by the SPRAM: 14-bit word address, 16-bit data.
- `clk` in 1: single clock, shared with the SPRAM `ram_clk`.
- `rst_n` in 1: asynchronous, active-low reset.
- `a_req` in 1: port A access request, held until `a_ack`.
- `a_we` in 1: port A write when 1, read when 0.
- `a_addr` in 14: port A word address.
- `a_wdata` in 16: port A write data.
- `a_ack` out 1: one-cycle pulse, port A request accepted this cycle.
- `a_rvalid` out 1: one-cycle pulse, `a_rdata` valid.
- `a_rdata` out 16: port A read data.
- `b_req`, `b_we`, `b_addr`, `b_wdata`, `b_ack`, `b_rvalid`, `b_rdata`: identical set for port B.
- `ram_addr` out 14: to SPRAM `ram_addr`.
- `ram_data_in` out 16: to SPRAM `ram_data_in`.
- `ram_we` out 1: to SPRAM `ram_we`.
- `ram_data_out` in 16: from SPRAM `ram_data_out`.

## Operation
- Grant decision is combinational on `a_req`/`b_req` and `last` (last-granted port). The acknowledge and the RAM-side outputs are registered.
- Only one requester: it is granted.
- Both requesters: the port not equal to `last` is granted, then `last` updates to the granted port.
- Neither requester: no grant, `ram_we` is 0 next cycle, `ram_addr` and `ram_data_in` hold, and `last` is unchanged.
- On a grant at edge N:
  - `x_ack` = 1 for the cycle after edge N.
  - `ram_addr`, `ram_data_in` and `ram_we` load the granted port's `addr`, `wdata` and `we`.
- A requester seeing `x_ack` = 1 may drop `req` or present a new request in that same cycle. Back-to-back grants to one port are allowed when the other port is idle.
- Reads: a 2-bit pipeline tag (valid, port) follows each read access. `x_rdata` loads `ram_data_out` and `x_rvalid` pulses for the tagged port only. The other port's `rdata` holds its old value.
- Writes produce no `rvalid`.
- Read-after-write to the same address from either port returns the new data, because the SPRAM is sequential and accesses are serialised.
- Reset values:
  - All `ack`, `rvalid` and `ram_we` outputs are 0.
  - `ram_addr`, `ram_data_in` and both `rdata` outputs are 0.
  - `last` = B, so port A wins the first contention.
  - The pipeline tag is cleared.
- Reset asserted mid-operation: in-flight reads are discarded, no `rvalid` is issued after reset, and `ram_we` goes low immediately (asynchronously).

## Timing
- Edge N: request sampled and granted. `x_ack` and the RAM inputs are valid during cycle N..N+1.
- Edge N+1: SPRAM captures the access. `ram_data_out` is valid after N+1.
- Edge N+2: `x_rdata` is registered and `x_rvalid` = 1 during N+2..N+3.
- Read latency: 2 cycles from the acknowledging edge to `rvalid`.
- Throughput is 1 access per cycle aggregate. Under continuous contention each port gets every other cycle.
- A port is never granted twice in a row while the other port is requesting (worst-case wait is 1 cycle), except under the fixed-priority build.

## Configuration
- `SPRAM_ARB_FIXED_PRIO_EN` defined:
  - Port A always wins contention, and `last` is not used.
  - Port B is granted only in cycles where `a_req` = 0.
  - Starvation of B is permitted and is the CPU's responsibility.
- Undefined (default): round-robin as described above.

## Test plan
- Reset: hold `rst_n` = 0 with both `req` = 1. All outputs stay 0. Release: the first grant goes to A (`a_ack` at the first edge), then B on the next edge.
- Single-port write/read: A writes 0xBEEF to 0x1234, then A reads 0x1234. The second ack is followed 2 edges later by `a_rvalid` = 1 and `a_rdata` = 0xBEEF, with `b_rvalid` never asserted.
- Contention round-robin: `a_req` and `b_req` held high for 8 cycles reading addresses 0x0000 (A) and 0x3FFF (B), preloaded 0x1111 and 0x2222. Acks alternate A, B, A, B…; `a_rdata` = 0x1111 and `b_rdata` = 0x2222 on each respective `rvalid`.
- Cross-port coherence: B writes 0x00A5 to 0x0100 and A reads 0x0100 in the next cycle. `a_rdata` = 0x00A5.
- Reset mid-read: A read acked, then `rst_n` pulsed low for 1 cycle before N+2. No `a_rvalid` appears, and `ram_we` = 0 during reset.
- Fixed priority (macro defined): both ports request continuously for 6 cycles. Only `a_ack` pulses. `b_ack` asserts on the first cycle `a_req` = 0.
